mips_mc_controller_ws: RTL
==========================

// Module: mips_mc_controller_ws
// PURPOSE
//  Multi-cycle MIPS control unit with a memory wait-state handshake. Drives the datapath controls
//  for the multi-cycle core. Memory accesses stretch until mem_ready. Adds bne/slti/andi/jal/jr,
//  a wait-state timeout trap, an illegal-opcode trap and a retired-instruction counter.
// PARAMETERS
//  TMO_W    4   width of the wait-state counter
//  TMO_MAX  15  wait cycles tolerated without mem_ready before the bus-error trap (<= 2^TMO_W-1)
//  CNT_W    32  width of instret
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  opcode      in   6      IR[31:26]
//  func        in   6      IR[5:0]
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory completes current access this cycle
//  reg_dst     out  2      00 rt, 01 rd, 10 r31
//  mem_to_reg  out  2      00 ALUOut, 01 MDR, 10 PC
//  reg_write   out  1      register file write enable
//  pc_src      out  2      00 ALU result, 01 ALUOut, 10 jump target, 11 reg A
//  alu_ctrl    out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  pc_write    out  1      final PC enable (branch condition already resolved)
//  lord        out  1      memory address: 0 PC, 1 ALUOut
//  ir_write    out  1      IR load
//  memread     out  1      memory read request
//  memwrite    out  1      memory write request
//  alu_srca    out  1      0 PC, 1 reg A
//  alu_srcb    out  2      00 B, 01 4, 10 sext imm, 11 sext imm<<2
//  bus_err     out  1      sticky: wait-state timeout
//  illegal     out  1      sticky: undecodable opcode/func
//  instret     out  CNT_W  retired instruction count
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all outputs 0, counters 0. IDLE lasts one cycle, then FETCH.
//  - Outputs are a decode of the state, gated by mem_ready/zero where noted. No registered outputs
//    except bus_err, illegal and instret.
//  - FETCH: memread=1, lord=0, alu_srca=0, alu_srcb=01, alu_ctrl=010, pc_src=00.
//    ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
//  - DECODE: alu_srca=0, alu_srcb=11, alu_ctrl=010 (branch target into ALUOut).
//    Next state by opcode: 100011/101011 -> MEMADR, 000000 -> RTYPE (jr: func 001000 -> JR),
//    000100/000101 -> BRANCH, 001000/001010/001100 -> IMM_EX, 000010 -> JUMP, 000011 -> JAL,
//    otherwise -> HALT with illegal<=1. An undefined R-type func also -> HALT with illegal<=1.
//  - MEMADR: alu_srca=1, alu_srcb=10, alu_ctrl=010; -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD: memread=1, lord=1; hold until mem_ready, then MEMWB.
//  - MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01.
//  - MEMWR: memwrite=1, lord=1; retires on the mem_ready cycle.
//  - RTYPE: alu_srca=1, alu_srcb=00, alu_ctrl from func
//    (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt).
//  - RTYPE_WB: reg_write=1, reg_dst=01, mem_to_reg=00.
//  - IMM_EX: alu_srca=1, alu_srcb=10, alu_ctrl 010/111/000 (addi/slti/andi).
//  - IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00.
//  - BRANCH: alu_srca=1, alu_srcb=00, alu_ctrl=110, pc_src=01.
//    pc_write = zero (beq) or ~zero (bne).
//  - JUMP: pc_src=10, pc_write=1.
//  - JAL: pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10. PC still holds PC+4.
//  - JR: pc_src=11, pc_write=1.
//  - Retire: the last state of each instruction (MEMWB, MEMWR+ready, RTYPE_WB, IMM_WB, BRANCH,
//    JUMP, JAL, JR) returns to FETCH and increments instret by 1, modulo 2^CNT_W (wraps silently).
//  - Wait counter: cleared on entry to FETCH, MEMRD and MEMWR. Increments each cycle the state
//    waits with mem_ready=0. If mem_ready=0 while the count already equals TMO_MAX, the next
//    state is HALT and bus_err<=1. mem_ready arriving on that same cycle wins (no error).
//  - HALT: all controls 0 (no memory requests); hold until reset. Flags stay sticky.
//  - Reset mid-access drops memread/memwrite immediately (async); partial state is discarded.
// TESTING
//  - Reset, then mem_ready=1 constant, lw (100011) -> 5 cycles FETCH..MEMWB; reg_write=1,
//    mem_to_reg=01 in cycle 5; instret=1.
//  - FETCH with mem_ready low for 3 cycles -> memread held 4 cycles; ir_write/pc_write pulse
//    only on the 4th.
//  - beq with zero=0 -> pc_write=0; bne with zero=0 -> pc_write=1 in BRANCH; both retire
//    (instret +1 each).
//  - jal -> reg_dst=10, mem_to_reg=10, pc_src=10, reg_write=pc_write=1 in one cycle.
//    jr (func 001000) -> pc_src=11.
//  - mem_ready held 0 in MEMRD -> HALT after TMO_MAX+1 wait cycles, bus_err=1, memread=0
//    thereafter. Repeat with ready on the final cycle -> no error.
//  - Opcode 111111 -> illegal=1, HALT. Assert rst=0 mid-HALT -> flags/instret cleared.
//    Preload instret=2^CNT_W-1 (CNT_W=4 build) -> wraps to 0.

Source files
------------

// File: rtl/mips_mc_controller_ws.sv
// Multi-cycle MIPS control unit with memory wait-state handshake,
// wait-state timeout trap, illegal-opcode trap and retired-instruction counter.
module mips_mc_controller_ws #(
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned TMO_MAX = 15,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctrl,
    output logic             pc_write,
    output logic             lord,
    output logic             ir_write,
    output logic             memread,
    output logic             memwrite,
    output logic             alu_srca,
    output logic [1:0]       alu_srcb,
    output logic             bus_err,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE,
        RTYPE_WB, IMM_EX, IMM_WB, BRANCH, JUMP, JAL, JR, HALT
    } state_t;

    state_t           state, next_state;
    logic [TMO_W-1:0] wait_cnt;
    logic             wait_exp;
    logic             in_wait;
    logic             retire, set_bus_err, set_illegal;
    logic [2:0]       func_alu;
    logic             func_valid;

    assign wait_exp = (wait_cnt == TMO_W'(TMO_MAX));
    assign in_wait  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

    // R-type function field to ALU operation
    always_comb begin
        func_alu   = ALU_ADD;
        func_valid = 1'b1;
        case (func)
            FN_ADD:  func_alu = ALU_ADD;
            FN_SUB:  func_alu = ALU_SUB;
            FN_AND:  func_alu = ALU_AND;
            FN_OR:   func_alu = ALU_OR;
            FN_SLT:  func_alu = ALU_SLT;
            default: func_valid = 1'b0;
        endcase
    end

    // Next-state and datapath control decode
    always_comb begin
        next_state  = state;
        retire      = 1'b0;
        set_bus_err = 1'b0;
        set_illegal = 1'b0;
        reg_dst     = 2'b00;
        mem_to_reg  = 2'b00;
        reg_write   = 1'b0;
        pc_src      = 2'b00;
        alu_ctrl    = 3'b000;
        pc_write    = 1'b0;
        lord        = 1'b0;
        ir_write    = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        alu_srca    = 1'b0;
        alu_srcb    = 2'b00;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                memread  = 1'b1;
                alu_srcb = 2'b01;
                alu_ctrl = ALU_ADD;
                ir_write = mem_ready;
                pc_write = mem_ready;
                if (mem_ready) begin
                    next_state = DECODE;
                end else if (wait_exp) begin
                    next_state  = HALT;
                    set_bus_err = 1'b1;
                end
            end
            DECODE: begin
                alu_srcb = 2'b11;
                alu_ctrl = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:               next_state = MEMADR;
                    OP_BEQ, OP_BNE:             next_state = BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI:  next_state = IMM_EX;
                    OP_J:                       next_state = JUMP;
                    OP_JAL:                     next_state = JAL;
                    OP_RTYPE: begin
                        if (func == FN_JR) begin
                            next_state = JR;
                        end else if (func_valid) begin
                            next_state = RTYPE;
                        end else begin
                            next_state  = HALT;
                            set_illegal = 1'b1;
                        end
                    end
                    default: begin
                        next_state  = HALT;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_srca   = 1'b1;
                alu_srcb   = 2'b10;
                alu_ctrl   = ALU_ADD;
                next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                memread = 1'b1;
                lord    = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end else if (wait_exp) begin
                    next_state  = HALT;
                    set_bus_err = 1'b1;
                end
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                next_state = FETCH;
                retire     = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                lord     = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end else if (wait_exp) begin
                    next_state  = HALT;
                    set_bus_err = 1'b1;
                end
            end
            RTYPE: begin
                alu_srca   = 1'b1;
                alu_ctrl   = func_alu;
                next_state = RTYPE_WB;
            end
            RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                next_state = FETCH;
                retire     = 1'b1;
            end
            IMM_EX: begin
                alu_srca   = 1'b1;
                alu_srcb   = 2'b10;
                alu_ctrl   = (opcode == OP_SLTI) ? ALU_SLT :
                             (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
                next_state = IMM_WB;
            end
            IMM_WB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
                retire     = 1'b1;
            end
            BRANCH: begin
                alu_srca   = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_src     = 2'b01;
                pc_write   = (opcode == OP_BNE) ? ~zero : zero;
                next_state = FETCH;
                retire     = 1'b1;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                next_state = FETCH;
                retire     = 1'b1;
            end
            JAL: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                next_state = FETCH;
                retire     = 1'b1;
            end
            JR: begin
                pc_src     = 2'b11;
                pc_write   = 1'b1;
                next_state = FETCH;
                retire     = 1'b1;
            end
            HALT:    next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    // State, wait counter, sticky flags and retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            illegal  <= 1'b0;
            instret  <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                wait_cnt <= '0;
            end else if (in_wait && !mem_ready) begin
                wait_cnt <= wait_cnt + TMO_W'(1);
            end
            if (set_bus_err) bus_err <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

endmodule
